mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter onto a single
// memory port. One transfer outstanding at a time. Data normally wins, but an
// instruction fetch is forced through once data has won STARVE_LIMIT
// consecutive grants while a fetch was waiting.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch requester
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    // shared memory port
    output logic        m_valid,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        ACK     = 2'd3
    } state_t;

    // starvation counter is 3 bits wide, so the limit is clipped to that width
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t      state_q;
    logic [2:0]  starve_q;
    logic [2:0]  starve_d;
    logic        m_valid_q;
    logic        m_we_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic        i_ack_q;
    logic        d_ack_q;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;
    logic        grant_d;
    logic        grant_i;

    // Arbitration decision and next starvation count, only consumed in IDLE.
    always_comb begin
        grant_d  = d_req && (!i_req || (starve_q < LIMIT));
        grant_i  = !grant_d && i_req;
        starve_d = starve_q;
        if (grant_d && i_req) begin
            // saturate at the limit; a pending fetch makes this a "starving" grant
            if (starve_q < LIMIT) begin
                starve_d = starve_q + 3'd1;
            end
        end else if (grant_i) begin
            starve_d = '0;
        end
    end

    // Arbiter FSM with registered memory-port and completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            m_valid_q <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // m_ready is ignored here: nothing is outstanding
                    if (grant_d) begin
                        state_q   <= SERVE_D;
                        starve_q  <= starve_d;
                        m_valid_q <= 1'b1;
                        m_we_q    <= d_we;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                    end else if (grant_i) begin
                        state_q   <= SERVE_I;
                        starve_q  <= starve_d;
                        m_valid_q <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= i_addr;
                    end
                end
                SERVE_I: begin
                    // address/control held from the grant until memory completes
                    if (m_ready) begin
                        state_q   <= ACK;
                        m_valid_q <= 1'b0;
                        i_rdata_q <= m_rdata;
                        i_ack_q   <= 1'b1;
                    end
                end
                SERVE_D: begin
                    if (m_ready) begin
                        state_q   <= ACK;
                        m_valid_q <= 1'b0;
                        d_rdata_q <= m_rdata;
                        d_ack_q   <= 1'b1;
                    end
                end
                ACK: begin
                    // the ack pulse lasts exactly this one cycle; the requester
                    // drops its request before the next IDLE evaluation
                    state_q <= IDLE;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario tasks with a queue of expected
// completions (requester kind + read data) consumed as acks appear.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        busy;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, m_valid, m_we, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {i_ack, d_ack, m_valid, m_we, busy});
        end
        total++;
        if (m_addr !== 32'h0) begin bad++; $display("FAIL reset_maddr: got %h want 0", m_addr); end
        total++;
        if (m_wdata !== 32'h0) begin bad++; $display("FAIL reset_mwdata: got %h want 0", m_wdata); end
        total++;
        if (i_rdata !== 32'h0) begin bad++; $display("FAIL reset_irdata: got %h want 0", i_rdata); end
        total++;
        if (d_rdata !== 32'h0) begin bad++; $display("FAIL reset_drdata: got %h want 0", d_rdata); end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        exp_t e;
        int   cyc = 0;
        bit   got = 0;
        i_addr  = 32'h0000_0010;
        m_ready = 1'b1;
        m_rdata = 32'h8C01_0004;
        i_req   = 1'b1;
        sb.push_back('{0, 32'h8C01_0004});
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (m_valid) begin
                total++;
                if (m_addr !== 32'h10 || m_we !== 1'b0) begin
                    bad++;
                    $display("FAIL fetch_port: got addr=%h we=%b want addr=00000010 we=0", m_addr, m_we);
                end
            end
            if (i_ack || d_ack) got = 1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL fetch_timeout: got no ack want i_ack");
            sb.delete();
        end else begin
            e = sb.pop_front();
            if (i_ack !== !e.is_d || d_ack !== e.is_d || i_rdata !== e.rdata) begin
                bad++;
                $display("FAIL fetch_ack: got i_ack=%b d_ack=%b rdata=%h want i_ack=1 d_ack=0 rdata=%h",
                         i_ack, d_ack, i_rdata, e.rdata);
            end
            total++;
            if (cyc != 2) begin bad++; $display("FAIL fetch_latency: got %0d want 2", cyc); end
        end
        i_req   = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        total++;
        if (i_ack !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL fetch_pulse: got i_ack=%b busy=%b want 0 0", i_ack, busy);
        end
    endtask

    task automatic test_store_wait();
        exp_t e;
        int   cyc = 0;
        int   vcyc = 0;
        bit   got = 0;
        bit   i_seen = 0;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0100;
        d_wdata = 32'hDEAD_BEEF;
        m_ready = 1'b0;
        m_rdata = 32'h0BAD_F00D;
        d_req   = 1'b1;
        sb.push_back('{1, 32'h0BAD_F00D});
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (i_ack) i_seen = 1;
            if (m_valid) begin
                vcyc++;
                total++;
                if ({m_we, m_addr, m_wdata} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) begin
                    bad++;
                    $display("FAIL store_stable: got we=%b addr=%h wdata=%h want 1 00000100 deadbeef",
                             m_we, m_addr, m_wdata);
                end
                if (vcyc == 4) m_ready = 1'b1;
            end
            if (d_ack) got = 1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL store_timeout: got no d_ack want d_ack");
            sb.delete();
        end else begin
            e = sb.pop_front();
            if (d_ack !== e.is_d || d_rdata !== e.rdata) begin
                bad++;
                $display("FAIL store_ack: got d_ack=%b rdata=%h want 1 %h", d_ack, d_rdata, e.rdata);
            end
            total++;
            if (vcyc != 4) begin bad++; $display("FAIL store_valid_len: got %0d want 4", vcyc); end
        end
        d_req   = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        if (i_ack) i_seen = 1;
        total++;
        if (d_ack !== 1'b0 || i_seen) begin
            bad++;
            $display("FAIL store_pulse: got d_ack=%b i_ack_seen=%b want 0 0", d_ack, i_seen);
        end
    endtask

    // Both requesters held high; the expected grant pattern is D,D,D,D,I repeating.
    task automatic test_starve(input int n, input logic [31:0] val);
        exp_t e;
        int   cyc = 0;
        int   acks = 0;
        for (int k = 0; k < n; k++) sb.push_back('{(k % 5) != 4, val});
        i_addr  = 32'h0000_0200;
        d_addr  = 32'h0000_0300;
        d_we    = 1'b0;
        m_rdata = val;
        m_ready = 1'b1;
        i_req   = 1'b1;
        d_req   = 1'b1;
        while (acks < n && cyc < 40 * n) begin
            @(negedge clk);
            cyc++;
            if (i_ack || d_ack) begin
                total++;
                if (i_ack && d_ack) begin
                    bad++;
                    $display("FAIL starve_coincident: got i_ack=1 d_ack=1 want one");
                end
                e = sb.pop_front();
                total++;
                if (d_ack !== e.is_d || (d_ack ? d_rdata : i_rdata) !== e.rdata) begin
                    bad++;
                    $display("FAIL starve_order[%0d]: got d_ack=%b rdata=%h want d_ack=%b rdata=%h",
                             acks, d_ack, (d_ack ? d_rdata : i_rdata), e.is_d, e.rdata);
                end
                acks++;
                if (acks == n) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                end
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        if (acks < n) begin
            total++;
            bad++;
            $display("FAIL starve_timeout: got %0d acks want %0d", acks, n);
            sb.delete();
        end
        m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int   cyc = 0;
        int   cyc_d = -1;
        int   cyc_i = -1;
        i_addr  = 32'h0000_0400;
        d_addr  = 32'h0000_0500;
        d_we    = 1'b0;
        m_rdata = 32'h0000_AAAA;
        m_ready = 1'b1;
        sb.push_back('{1, 32'h0000_AAAA});
        i_req   = 1'b1;
        d_req   = 1'b1;
        while ((cyc_d < 0 || cyc_i < 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (i_ack || d_ack) begin
                total++;
                if (i_ack && d_ack) begin
                    bad++;
                    $display("FAIL simul_coincident: got i_ack=1 d_ack=1 want one");
                end
                e = sb.pop_front();
                total++;
                if (d_ack !== e.is_d || (d_ack ? d_rdata : i_rdata) !== e.rdata) begin
                    bad++;
                    $display("FAIL simul_order: got d_ack=%b rdata=%h want d_ack=%b rdata=%h",
                             d_ack, (d_ack ? d_rdata : i_rdata), e.is_d, e.rdata);
                end
                if (d_ack) begin
                    cyc_d   = cyc;
                    d_req   = 1'b0;
                    m_rdata = 32'h0000_BBBB;
                    sb.push_back('{0, 32'h0000_BBBB});
                end else begin
                    cyc_i = cyc;
                    i_req = 1'b0;
                end
            end
        end
        i_req   = 1'b0;
        d_req   = 1'b0;
        m_ready = 1'b0;
        total++;
        if (cyc_d < 0 || cyc_i < 0 || (cyc_i - cyc_d) != 3) begin
            bad++;
            $display("FAIL simul_followup: got d_at=%0d i_at=%0d want i 3 cycles after d", cyc_d, cyc_i);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ack_seen = 0;
        i_addr  = 32'h0000_0600;
        d_addr  = 32'h0000_0700;
        d_we    = 1'b1;
        d_wdata = 32'h1111_2222;
        m_ready = 1'b0;
        i_req   = 1'b1;
        d_req   = 1'b1;
        @(negedge clk);
        total++;
        if (m_valid !== 1'b1 || m_addr !== 32'h700) begin
            bad++;
            $display("FAIL rmid_grant: got valid=%b addr=%h want 1 00000700", m_valid, m_addr);
        end
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rmid_state: got valid=%b busy=%b drdata=%h irdata=%h want 0 0 0 0",
                     m_valid, busy, d_rdata, i_rdata);
        end
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (d_ack || i_ack) ack_seen = 1;
        end
        m_ready = 1'b0;
        total++;
        if (ack_seen) begin bad++; $display("FAIL rmid_noack: got ack=1 want 0"); end
        // starvation count must restart at zero: four data grants before fetch
        test_starve(5, 32'h55AA_33CC);
    endtask

    task automatic test_idle_ready();
        bit bad_seen = 0;
        i_req   = 1'b0;
        d_req   = 1'b0;
        m_ready = 1'b1;
        m_rdata = 32'hFFFF_0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (i_ack || d_ack || busy || i_rdata !== 32'h55AA_33CC || d_rdata !== 32'h55AA_33CC) begin
                bad++;
                bad_seen = 1;
                $display("FAIL idle_ready[%0d]: got ack=%b%b busy=%b irdata=%h drdata=%h want 00 0 55aa33cc 55aa33cc",
                         k, i_ack, d_ack, busy, i_rdata, d_rdata);
            end
        end
        m_ready = 1'b0;
    endtask

    initial begin
        clk     = 1'b0;
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        total   = 0;
        bad     = 0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_store_wait();
        test_starve(10, 32'h1234_5678);
        test_simultaneous();
        test_reset_mid();
        test_idle_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
